aes_round_sequencer: RTL and testbench

Iterative AES-128 encryption controller. Accepts a 128-bit block plus the 1408-bit expanded key schedule from the key-schedule block, and runs one AES round per clock through a single-round combinational sub-module. It replaces the fully unrolled combinational round chain with a 10-cycle iterative datapath. Sits between the USB data buffer (upstream, valid/ready) and the output FIFO (downstream, valid/ready).

---
 rtl/aes_pkg.sv | 39 +++
 rtl/aes_round_sequencer_if.sv | 26 ++
 rtl/aes_round_step.sv | 45 ++++
 rtl/aes_round_sequencer.sv | 127 ++++++++++++
 tb/tb_aes_round_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, sequencer state type and byte-level helpers.
//   BLOCK_W    : state / round-key width (128)
//   NUM_ROUNDS : rounds after the initial AddRoundKey (10)
//   SCHED_W    : expanded key schedule width (1408)
//   sbox()     : forward S-box lookup
//   xtime()    : multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1
package aes_pkg;

    localparam int unsigned BLOCK_W    = 128;
    localparam int unsigned NUM_ROUNDS = 10;
    localparam int unsigned SCHED_W    = BLOCK_W * (NUM_ROUNDS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_e;

    // Entry n occupies bits [8n : 8n+7] (ascending range, MSB first).
    localparam logic [0:2047] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Block-level handshake bundle for the AES round sequencer.
//   schedule  : expanded key, round key k at bits [128k : 128k+127]
//   in_data / in_valid / in_ready    : plaintext side (valid/ready)
//   out_data / out_valid / out_ready : ciphertext side (valid/ready)
// master = upstream/downstream environment, slave = sequencer.
interface aes_round_sequencer_if;

    logic [0:aes_pkg::SCHED_W-1] schedule;
    logic [0:aes_pkg::BLOCK_W-1] in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [0:aes_pkg::BLOCK_W-1] out_data;
    logic                        out_valid;
    logic                        out_ready;

    modport master (
        output schedule, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  schedule, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/aes_round_step.sv
// One combinational AES encryption round:
// SubBytes -> ShiftRows -> MixColumns (skipped when final_i) -> AddRoundKey.
//   state_i : round input state, byte 0 in bits [127:120]
//   rkey_i  : round key, same byte order
//   final_i : last round, no MixColumns
//   state_o : round output state
module aes_round_step
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state_i,
    input  logic [BLOCK_W-1:0] rkey_i,
    input  logic               final_i,
    output logic [BLOCK_W-1:0] state_o
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    // Byte i is row (i % 4), column (i / 4).
    always_comb begin
        sb      = '{default: '0};
        sr      = '{default: '0};
        mc      = '{default: '0};
        state_o = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            sb[i] = sbox(state_i[BLOCK_W-1-8*i -: 8]);
        end
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int unsigned c = 0; c < 4; c++) begin
            mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        for (int unsigned i = 0; i < 16; i++) begin
            state_o[BLOCK_W-1-8*i -: 8] = (final_i ? sr[i] : mc[i]) ^ rkey_i[BLOCK_W-1-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 encryption controller: initial AddRoundKey on accept,
// then one round per clock through aes_round_step, result held in DONE
// until the downstream handshake. A new block may be accepted in the same
// cycle the previous result is retired.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : aes_round_sequencer_if.slave (schedule, in/out valid-ready)
//   busy      : high while rounds are running
//   round_idx : current round counter 0..10
// Build option AES_KEY_LATCH_EN: capture the whole schedule on accept so
// upstream may change it right after the accept edge; otherwise schedule
// must stay stable until the result handshake.
module aes_round_sequencer
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    aes_round_sequencer_if.slave bus,
    output logic                 busy,
    output logic [3:0]           round_idx
);

    seq_state_e         fsm_q, fsm_d;
    logic [3:0]         round_idx_q, round_idx_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic               accept;
    logic               in_ready;

    logic [SCHED_W-1:0] sched_live;
    logic [SCHED_W-1:0] key_src;
    logic [BLOCK_W-1:0] in_blk;
    logic [BLOCK_W-1:0] rk0;
    logic [BLOCK_W-1:0] rk_cur;
    logic [10:0]        rk_base;
    logic               last_round;
    logic [BLOCK_W-1:0] step_out;

    // Ascending bus ranges map onto descending vectors with bit 0 as MSB.
    assign sched_live = bus.schedule;
    assign in_blk     = bus.in_data;
    assign rk0        = sched_live[SCHED_W-1 -: BLOCK_W];

`ifdef AES_KEY_LATCH_EN
    logic [SCHED_W-1:0] key_q, key_d;

    always_comb key_d = accept ? sched_live : key_q;

    always_ff @(posedge clk) begin
        key_q <= key_d;
    end

    assign key_src = key_q;
`else
    assign key_src = sched_live;
`endif

    // Round key k starts 128*k bits below the top of the schedule.
    assign rk_base    = 11'(SCHED_W - 1) - {round_idx_q, 7'b0};
    assign rk_cur     = key_src[rk_base -: BLOCK_W];
    assign last_round = (round_idx_q == 4'(NUM_ROUNDS));

    aes_round_step u_step (
        .state_i (data_q),
        .rkey_i  (rk_cur),
        .final_i (last_round),
        .state_o (step_out)
    );

    always_comb begin
        fsm_d       = fsm_q;
        round_idx_d = round_idx_q;
        data_d      = data_q;
        in_ready    = 1'b0;
        busy        = 1'b0;
        accept      = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                accept   = bus.in_valid;
            end
            RUN: begin
                busy   = 1'b1;
                data_d = step_out;
                if (last_round) begin
                    fsm_d = DONE;
                end else begin
                    round_idx_d = round_idx_q + 4'd1;
                end
            end
            DONE: begin
                in_ready = bus.out_ready;
                if (bus.out_ready && bus.in_valid) begin
                    accept = 1'b1;
                end else if (bus.out_ready) begin
                    fsm_d       = IDLE;
                    round_idx_d = '0;
                end
            end
            default: begin
                fsm_d       = IDLE;
                round_idx_d = '0;
            end
        endcase
        if (accept) begin
            data_d      = in_blk ^ rk0;
            round_idx_d = 4'd1;
            fsm_d       = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            round_idx_q <= '0;
            data_q      <= '0;
        end else begin
            fsm_q       <= fsm_d;
            round_idx_q <= round_idx_d;
            data_q      <= data_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (fsm_q == DONE);
    assign bus.out_data  = data_q;
    assign round_idx     = round_idx_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: FIPS-197 vectors, latency,
// back-to-back, backpressure, mid-run reset, optional key latch, then
// randomized traffic scored against a byte-array AES reference model.
module tb_aes_round_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [3:0] round_idx;

    aes_round_sequencer_if bus ();

    aes_round_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .round_idx (round_idx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] ref_sbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = (x << n) | (x >> (8 - n));
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            ref_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] ref_expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] s;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) s[1407-32*i -: 32] = w[i];
        return s;
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [1407:0] sch, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ sch[1407-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = ref_sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c+r] = t[4*((c+r)%4)+r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int k = 0; k < 4; k++) a[k] = s[4*c+k];
                    for (int k = 0; k < 4; k++)
                        s[4*c+k] = gmul(8'h02, a[k]) ^ gmul(8'h03, a[(k+1)%4]) ^ a[(k+2)%4] ^ a[(k+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ sch[1407-128*rnd-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        if (!bus.out_valid) check_eq("out_valid_timeout", 128'(0), 128'(1));
    endtask

    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic [1407:0] sch1, sch2;

    initial begin
        int            n;
        int            k;
        logic [127:0]  exp_q [$];
        logic [127:0]  exp_ct;
        logic [127:0]  key_r, pt_r, held;
        logic          inflight, pending, hold_valid, seen, fire_in, fire_out;
        int            acc_edge, issued, done_cnt;

        build_sbox();
        sch1 = ref_expand(KEY1);
        sch2 = ref_expand(KEY2);

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_data   = '0;
        bus.schedule  = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check_eq("rst_round_idx", 128'(round_idx), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_in_ready", 128'(bus.in_ready), 128'(1));
        check_eq("rst_out_data", bus.out_data, 128'(0));

        // FIPS-197 vector, latency, RUN ignores in_valid, then backpressure
        bus.schedule = sch1;
        bus.in_data  = PT1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_data = PT2;
        check_eq("run_round_idx", 128'(round_idx), 128'(1));
        check_eq("run_busy", 128'(busy), 128'(1));
        check_eq("run_in_ready", 128'(bus.in_ready), 128'(0));
        wait_out(n);
        check_eq("fips_latency", 128'(n), 128'(10));
        check_eq("fips_ct", bus.out_data, CT1);
        check_eq("done_round_idx", 128'(round_idx), 128'(10));
        check_eq("done_busy", 128'(busy), 128'(0));
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_in_ready", 128'(bus.in_ready), 128'(0));
            check_eq("bp_out_valid", 128'(bus.out_valid), 128'(1));
            check_eq("bp_out_data", bus.out_data, CT1);
            tick();
        end

        // Drain and refill in the same cycle
        bus.schedule  = sch2;
        bus.out_ready = 1'b1;
        #1;
        check_eq("refill_in_ready", 128'(bus.in_ready), 128'(1));
        tick();
        bus.in_valid = 1'b0;
        check_eq("refill_out_valid", 128'(bus.out_valid), 128'(0));
        check_eq("refill_round_idx", 128'(round_idx), 128'(1));
        wait_out(n);
        check_eq("v2_latency", 128'(n), 128'(10));
        check_eq("v2_ct", bus.out_data, CT2);
        tick();
        check_eq("drain_out_valid", 128'(bus.out_valid), 128'(0));
        check_eq("drain_round_idx", 128'(round_idx), 128'(0));
        check_eq("drain_in_ready", 128'(bus.in_ready), 128'(1));

        // Back-to-back with in_valid and out_ready held high
        bus.schedule = sch1;
        bus.in_data  = PT1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_data = PT2;
        wait_out(n);
        check_eq("b2b_a_latency", 128'(n), 128'(10));
        check_eq("b2b_a_ct", bus.out_data, CT1);
        bus.schedule = sch2;
        tick();
        bus.in_valid = 1'b0;
        check_eq("b2b_b_round_idx", 128'(round_idx), 128'(1));
        wait_out(n);
        check_eq("b2b_gap", 128'(n + 1), 128'(11));
        check_eq("b2b_b_ct", bus.out_data, CT2);
        tick();

        // Reset in the middle of a run
        bus.out_ready = 1'b0;
        bus.schedule  = sch1;
        bus.in_data   = PT1;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        k = 0;
        while (round_idx != 4'd5 && k < 20) begin
            tick();
            k++;
        end
        check_eq("mid_round_idx", 128'(round_idx), 128'(5));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_out_valid", 128'(bus.out_valid), 128'(0));
        check_eq("mid_rst_round_idx", 128'(round_idx), 128'(0));
        check_eq("mid_rst_in_ready", 128'(bus.in_ready), 128'(1));
        check_eq("mid_rst_busy", 128'(busy), 128'(0));
        bus.schedule  = sch2;
        bus.in_data   = PT2;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        wait_out(n);
        check_eq("post_rst_ct", bus.out_data, CT2);
        tick();

`ifdef AES_KEY_LATCH_EN
        // Schedule withdrawn right after accept
        bus.schedule = sch1;
        bus.in_data  = PT1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.schedule = '0;
        wait_out(n);
        check_eq("latch_ct", bus.out_data, CT1);
        tick();
`endif

        // Randomized traffic with random gaps and backpressure
        bus.in_valid = 1'b0;
        tick();
        inflight   = 1'b0;
        pending    = 1'b0;
        hold_valid = 1'b0;
        seen       = 1'b0;
        held       = '0;
        exp_ct     = '0;
        acc_edge   = 0;
        issued     = 0;
        done_cnt   = 0;
        for (int it = 0; it < 1500 && done_cnt < 40; it++) begin
            if (inflight && bus.out_valid && !seen) begin
                check_eq("rand_latency", 128'(it - acc_edge), 128'(10));
                seen = 1'b1;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!pending && issued < 40 && (!inflight || (bus.out_valid && bus.out_ready))
                && $urandom_range(0, 1) == 1) begin
                key_r        = {$urandom, $urandom, $urandom, $urandom};
                pt_r         = {$urandom, $urandom, $urandom, $urandom};
                bus.schedule = ref_expand(key_r);
                bus.in_data  = pt_r;
                exp_ct       = ref_encrypt(ref_expand(key_r), pt_r);
                pending      = 1'b1;
            end
            bus.in_valid = pending;
            #1;
            if (hold_valid) begin
                check_eq("rand_bp_valid", 128'(bus.out_valid), 128'(1));
                check_eq("rand_bp_data", bus.out_data, held);
            end
            fire_in  = bus.in_valid && bus.in_ready;
            fire_out = bus.out_valid && bus.out_ready;
            if (fire_out) begin
                if (exp_q.size() == 0) begin
                    check_eq("rand_unexpected_out", 128'(1), 128'(0));
                end else begin
                    check_eq("rand_ct", bus.out_data, exp_q.pop_front());
                end
                done_cnt++;
                inflight = 1'b0;
            end
            hold_valid = bus.out_valid && !bus.out_ready;
            held       = bus.out_data;
            if (fire_in) begin
                exp_q.push_back(exp_ct);
                inflight = 1'b1;
                pending  = 1'b0;
                seen     = 1'b0;
                acc_edge = it + 1;
                issued++;
            end
            @(posedge clk);
            #1;
        end
        check_eq("rand_done", 128'(done_cnt), 128'(40));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
